// File: rtl/usb_fs_phy_pkg.sv
// Shared encodings and constants for the usb_fs_phy full-speed transceiver PHY.
package usb_fs_phy_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  localparam int CLK_PER_BIT  = 4;
  localparam int RST_SE0_BITS = 31;
  localparam int RST_SE0_CLKS = RST_SE0_BITS * CLK_PER_BIT;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, WAIT} tx_state_t;

endpackage

// File: rtl/usb_fs_phy_rx.sv
// Receive path: pin synchronisers, DPLL bit recovery, SYNC detection, NRZI decode,
// bit destuffing and LSB-first byte assembly.
module usb_fs_phy_rx
  import usb_fs_phy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rxdp,
  input  logic       rxdn,
  input  logic       blank,
  output logic [1:0] line_state,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic [7:0] rx_data
);
  logic [2:0] meta_reg, sync_reg;   // {dn, dp, rxd}
  logic       rxd_prev;
  logic [1:0] phase;
  logic       last_level;
  logic [7:0] hist, shift;
  logic [2:0] bit_cnt, ones;
  logic       rxd_s, transition, sample, dec_bit;

  assign rxd_s      = sync_reg[0];
  assign line_state = sync_reg[2:1];
  assign transition = rxd_s != rxd_prev;
  // Phase restarts on every edge, so sampling lands on the third clock of each bit.
  assign sample     = (phase == 2'd2) && !transition;
  assign dec_bit    = rxd_s == last_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg   <= {LS_J, 1'b1};
      sync_reg   <= {LS_J, 1'b1};
      rxd_prev   <= 1'b1;
      phase      <= 2'd0;
      last_level <= 1'b1;
      hist       <= 8'hFF;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      ones       <= 3'd0;
      rx_valid   <= 1'b0;
      rx_active  <= 1'b0;
      rx_error   <= 1'b0;
      rx_data    <= 8'h00;
    end else begin
      meta_reg <= {rxdn, rxdp, rxd};
      sync_reg <= meta_reg;
      rxd_prev <= rxd_s;
      phase    <= transition ? 2'd1 : phase + 2'd1;
      rx_valid <= 1'b0;
      if (blank) begin
        last_level <= 1'b1;
        hist       <= 8'hFF;
        rx_active  <= 1'b0;
        rx_error   <= 1'b0;
      end else if (sample) begin
        if (line_state == LS_SE0) begin
          rx_active  <= 1'b0;
          rx_error   <= 1'b0;
          hist       <= 8'hFF;
          last_level <= 1'b1;
        end else if (!rx_active) begin
          last_level <= rxd_s;
          hist       <= {dec_bit, hist[7:1]};
          if ({dec_bit, hist[7:1]} == SYNC_BYTE) begin
            rx_active <= 1'b1;
            ones      <= 3'd1;
            bit_cnt   <= 3'd0;
          end
        end else if (line_state == LS_SE1) begin
          rx_error <= 1'b1;
        end else begin
          last_level <= rxd_s;
          // After an error the rest of the packet is ignored until EOP.
          if (!rx_error) begin
            if (ones == STUFF_LIMIT) begin
              ones <= 3'd0;
              if (dec_bit) rx_error <= 1'b1;
            end else begin
              ones    <= dec_bit ? ones + 3'd1 : 3'd0;
              shift   <= {dec_bit, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_valid <= 1'b1;
                rx_data  <= {dec_bit, shift[7:1]};
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/usb_fs_phy.sv
// USB full-speed PHY top: TX serialiser (SYNC, NRZI, stuffing, EOP) plus RX instance.
// Optional bus-reset detector enabled by defining USB_PHY_BUS_RST_EN.
module usb_fs_phy
  import usb_fs_phy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       phy_tx_mode,
  output logic       usb_rst,
  output logic       txdp,
  output logic       txdn,
  output logic       txoe,
  input  logic       rxd,
  input  logic       rxdp,
  input  logic       rxdn,
  input  logic [7:0] DataOut_i,
  input  logic       TxValid_i,
  output logic       TxReady_o,
  output logic       RxValid_o,
  output logic       RxActive_o,
  output logic       RxError_o,
  output logic [7:0] DataIn_o,
  output logic [1:0] LineState_o
);
  tx_state_t  tx_state;
  logic [1:0] tx_phase;
  logic [7:0] tx_shift;
  logic [3:0] tx_cnt;
  logic [2:0] tx_ones;
  logic       tx_line, tx_se0;
  logic [3:0] blank_cnt;
  logic       rx_blank, tx_bit_en, tx_next_bit;

  assign tx_bit_en   = tx_phase == 2'(CLK_PER_BIT - 1);
  assign tx_next_bit = (tx_cnt == 4'd8) ? DataOut_i[0] : tx_shift[0];

  assign txdp = (phy_tx_mode && tx_se0) ? 1'b0 : tx_line;
  assign txdn = phy_tx_mode ? (~tx_line & ~tx_se0) : tx_se0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= IDLE;
      tx_phase  <= 2'd0;
      tx_shift  <= 8'h00;
      tx_cnt    <= 4'd0;
      tx_ones   <= 3'd0;
      tx_line   <= 1'b1;
      tx_se0    <= 1'b0;
      txoe      <= 1'b1;
      TxReady_o <= 1'b0;
    end else begin
      tx_phase  <= tx_phase + 2'd1;
      TxReady_o <= 1'b0;
      case (tx_state)
        IDLE: if (TxValid_i) begin
          // First SYNC bit goes out on the start edge; bit timing restarts here.
          tx_state <= SYNC;
          tx_phase <= 2'd0;
          txoe     <= 1'b0;
          tx_line  <= SYNC_BYTE[0] ? tx_line : ~tx_line;
          tx_ones  <= {2'b00, SYNC_BYTE[0]};
          tx_shift <= {1'b0, SYNC_BYTE[7:1]};
          tx_cnt   <= 4'd1;
        end
        SYNC, DATA: if (tx_bit_en) begin
          if (tx_ones == STUFF_LIMIT) begin
            tx_line <= ~tx_line;
            tx_ones <= 3'd0;
          end else if (tx_cnt == 4'd8 && !TxValid_i) begin
            tx_state <= EOP1;
            tx_se0   <= 1'b1;
          end else begin
            tx_line <= tx_next_bit ? tx_line : ~tx_line;
            tx_ones <= tx_next_bit ? tx_ones + 3'd1 : 3'd0;
            if (tx_cnt == 4'd8) begin
              tx_state  <= DATA;
              TxReady_o <= 1'b1;
              tx_shift  <= {1'b0, DataOut_i[7:1]};
              tx_cnt    <= 4'd1;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_cnt   <= tx_cnt + 4'd1;
            end
          end
        end
        EOP1: if (tx_bit_en) tx_state <= EOP2;
        EOP2: if (tx_bit_en) begin
          tx_state <= WAIT;
          tx_se0   <= 1'b0;
          tx_line  <= 1'b1;
        end
        WAIT: if (tx_bit_en) begin
          tx_state <= IDLE;
          txoe     <= 1'b1;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Keep the receiver deaf to our own echo and the line settling after TX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   blank_cnt <= 4'd0;
    else if (!txoe)            blank_cnt <= 4'(2 * CLK_PER_BIT);
    else if (blank_cnt != 4'd0) blank_cnt <= blank_cnt - 4'd1;
  end
  assign rx_blank = !txoe || (blank_cnt != 4'd0);

  usb_fs_phy_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rxdp       (rxdp),
    .rxdn       (rxdn),
    .blank      (rx_blank),
    .line_state (LineState_o),
    .rx_valid   (RxValid_o),
    .rx_active  (RxActive_o),
    .rx_error   (RxError_o),
    .rx_data    (DataIn_o)
  );

`ifdef USB_PHY_BUS_RST_EN
  localparam int SE0_CW = $clog2(RST_SE0_CLKS);
  logic [SE0_CW-1:0] se0_cnt;

  // Counting clocks at a fixed 4 per bit avoids depending on DPLL phase during SE0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      se0_cnt <= '0;
      usb_rst <= 1'b0;
    end else if (LineState_o != LS_SE0) begin
      se0_cnt <= '0;
      usb_rst <= 1'b0;
    end else if (se0_cnt == SE0_CW'(RST_SE0_CLKS - 1)) begin
      usb_rst <= 1'b1;
    end else begin
      se0_cnt <= se0_cnt + 1'b1;
    end
  end
`else
  assign usb_rst = 1'b0;
`endif

endmodule

// File: tb/tb_usb_fs_phy.sv
// Self-checking bench for usb_fs_phy: TX bitstream model, RX byte scoreboard, bus reset.
module tb_usb_fs_phy;
  import usb_fs_phy_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       phy_tx_mode = 1'b1;
  logic       rxd = 1'b1;
  logic       rxdp = 1'b1;
  logic       rxdn = 1'b0;
  logic [7:0] DataOut_i = 8'h00;
  logic       TxValid_i = 1'b0;
  logic       usb_rst, txdp, txdn, txoe, TxReady_o;
  logic       RxValid_o, RxActive_o, RxError_o;
  logic [7:0] DataIn_o;
  logic [1:0] LineState_o;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] rx_q[$];
  logic       rx_level = 1'b1;
  int         rx_ones = 0;
  logic       exp_bus_rst;

  usb_fs_phy dut (
    .clk         (clk),
    .rst         (rst),
    .phy_tx_mode (phy_tx_mode),
    .usb_rst     (usb_rst),
    .txdp        (txdp),
    .txdn        (txdn),
    .txoe        (txoe),
    .rxd         (rxd),
    .rxdp        (rxdp),
    .rxdn        (rxdn),
    .DataOut_i   (DataOut_i),
    .TxValid_i   (TxValid_i),
    .TxReady_o   (TxReady_o),
    .RxValid_o   (RxValid_o),
    .RxActive_o  (RxActive_o),
    .RxError_o   (RxError_o),
    .DataIn_o    (DataIn_o),
    .LineState_o (LineState_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; pops the RX scoreboard on RxValid.
  task automatic rx_cycle();
    logic [7:0] exp;
    @(posedge clk); #1;
    if (RxValid_o) begin
      check("rx_pending", 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0) begin
        exp = rx_q.pop_front();
        check("rx_data", 32'(DataIn_o), 32'(exp));
        $display("rx byte: got %02h want %02h", DataIn_o, exp);
      end
    end
  endtask

  task automatic sym(input logic [1:0] ls);
    rxdp = ls[0];
    rxdn = ls[1];
    if (ls == LS_J) rxd = 1'b1;
    else if (ls == LS_K) rxd = 1'b0;
    repeat (CLK_PER_BIT) rx_cycle();
  endtask

  task automatic send_bit(input logic b);
    if (!b) rx_level = ~rx_level;
    sym(rx_level ? LS_J : LS_K);
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = SYNC_BYTE;
    rx_level = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(s[i]);
    rx_ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_q.push_back(d);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      rx_ones = d[i] ? rx_ones + 1 : 0;
      if (rx_ones == 6) begin
        send_bit(1'b0);
        rx_ones = 0;
      end
    end
  endtask

  // Builds the expected symbol stream ({se0, level} per bit) and TxReady cycles, then
  // runs the packet cycle by cycle, feeding bytes as the DUT consumes them.
  task automatic tx_packet(input logic [7:0] b0, input logic [7:0] b1, input logic mode);
    logic [1:0] sq[$];
    int         ready_at[$];
    logic [7:0] bytes[3];
    logic       level, exp_rdy, b;
    logic [1:0] s;
    int         ones, n, consumed;
    logic [2:0] exp_pins;
    bytes[0] = SYNC_BYTE; bytes[1] = b0; bytes[2] = b1;
    level = 1'b1; ones = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) ready_at.push_back(4 * sq.size());
      for (int i = 0; i < 8; i++) begin
        b = bytes[k][i];
        if (!b) level = ~level;
        ones = b ? ones + 1 : 0;
        sq.push_back({1'b0, level});
        if (ones == 6) begin
          level = ~level;
          ones = 0;
          sq.push_back({1'b0, level});
        end
      end
    end
    sq.push_back({1'b1, level});
    sq.push_back({1'b1, level});
    sq.push_back(2'b01);
    n = sq.size();
    phy_tx_mode = mode;
    DataOut_i = b0;
    TxValid_i = 1'b1;
    consumed = 0;
    for (int c = 0; c <= 4 * n; c++) begin
      @(posedge clk); #1;
      if (c < 4 * n) begin
        s = sq[c / 4];
        exp_pins = {1'b0, mode ? (~s[0] & ~s[1]) : s[1], (mode && s[1]) ? 1'b0 : s[0]};
      end else begin
        exp_pins = 3'b101;
      end
      check("tx_pins", 32'({txoe, txdn, txdp}), 32'(exp_pins));
      exp_rdy = 1'b0;
      foreach (ready_at[j]) if (ready_at[j] == c) exp_rdy = 1'b1;
      check("tx_ready", 32'(TxReady_o), 32'(exp_rdy));
      if (TxReady_o) begin
        consumed++;
        if (consumed == 1) DataOut_i = b1;
        else TxValid_i = 1'b0;
      end
    end
    TxValid_i = 1'b0;
    $display("tx packet %02h %02h mode %0d: %0d bits, %0d bytes consumed", b0, b1, mode, n, consumed);
  endtask

  initial begin
`ifdef USB_PHY_BUS_RST_EN
    exp_bus_rst = 1'b1;
`else
    exp_bus_rst = 1'b0;
`endif
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txoe", 32'(txoe), 32'd1);
    check("rst_txdp_txdn", 32'({txdp, txdn}), 32'b10);
    check("rst_linestate", 32'(LineState_o), 32'(LS_J));
    check("rst_rx_flags", 32'({RxValid_o, RxActive_o, RxError_o}), 32'd0);
    check("rst_datain", 32'(DataIn_o), 32'd0);
    check("rst_ready_usbrst", 32'({TxReady_o, usb_rst}), 32'd0);
    rst = 1'b0;
    repeat (6) rx_cycle();
    check("idle_txoe", 32'(txoe), 32'd1);
    check("idle_linestate", 32'(LineState_o), 32'(LS_J));

    // TX: two plain bytes in differential mode, then 0xFF stuffing in single-ended mode
    tx_packet(8'h00, 8'hA5, 1'b1);
    repeat (10) rx_cycle();
    tx_packet(8'hFF, 8'h00, 1'b0);
    repeat (20) rx_cycle();

    // RX: SYNC + 0xC3 + EOP
    send_sync();
    send_byte(8'hC3);
    check("rx_active_pkt", 32'(RxActive_o), 32'd1);
    check("rx_error_pkt", 32'(RxError_o), 32'd0);
    sym(LS_SE0);
    sym(LS_SE0);
    check("rx_active_eop", 32'(RxActive_o), 32'd0);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("rx packet C3 done, active %0d", RxActive_o);
    repeat (4) sym(LS_J);

    // RX: stuffing violation, partial byte must not produce RxValid
    send_sync();
    check("rx_linestate_k", 32'(LineState_o), 32'(LS_K));
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("rx_error_set", 32'({RxActive_o, RxError_o}), 32'b11);
    sym(LS_SE0);
    sym(LS_SE0);
    check("rx_error_clear", 32'({RxActive_o, RxError_o}), 32'b00);
    $display("rx stuff-error packet done, error %0d", RxError_o);
    repeat (4) sym(LS_J);

    // Bus reset: long SE0
    rxdp = 1'b0; rxdn = 1'b0; rxd = 1'b0;
    repeat (110) rx_cycle();
    check("bus_rst_early", 32'(usb_rst), 32'd0);
    check("se0_linestate", 32'(LineState_o), 32'(LS_SE0));
    repeat (20) rx_cycle();
    check("bus_rst_set", 32'(usb_rst), 32'(exp_bus_rst));
    sym(LS_J);
    check("bus_rst_clear", 32'(usb_rst), 32'd0);
    $display("bus reset test: usb_rst expected %0d", exp_bus_rst);
    repeat (4) sym(LS_J);

    // Reset in the middle of a TX packet
    phy_tx_mode = 1'b1;
    DataOut_i = 8'h55;
    TxValid_i = 1'b1;
    repeat (40) rx_cycle();
    check("mid_tx_txoe", 32'(txoe), 32'd0);
    rst = 1'b1;
    TxValid_i = 1'b0;
    #1;
    check("abort_pins", 32'({txoe, txdp, txdn}), 32'b110);
    check("abort_ready", 32'(TxReady_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) rx_cycle();
    check("post_abort_idle", 32'({txoe, txdp}), 32'b11);
    $display("mid-packet reset test done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
